bc_seq_ctrl: RTL and testbench

Parametrised control unit (bloco de controle) for the iterative datapath. It sequences load enables and mux selects through a fixed init step, then loops the 4-step compute body n_iter times. Adds an inicio/busy/done handshake, an iteration counter, and pause/hold. It sits beside the datapath (BO) and drives its LX/LS/LH/H/M0/M1/M2 controls directly.

---
 rtl/bc_seq_ctrl.sv | 112 +++++++++++
 tb/tb_bc_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_seq_ctrl.sv
// Control unit for the iterative datapath: an init step, then the 4-step body n_iter times.
// Start/busy/done handshake, a pass counter, and a pause that freezes the body with loads masked.
module bc_seq_ctrl #(
   parameter int SEL_W  = 2,
   parameter int ITER_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inicio,
   input  logic [ITER_W-1:0] n_iter,
   input  logic              pause,
   output logic              LX,
   output logic              LS,
   output logic              LH,
   output logic              H,
   output logic [SEL_W-1:0]  M0,
   output logic [SEL_W-1:0]  M1,
   output logic [SEL_W-1:0]  M2,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MUL   = 3'd2,
      S_ACC   = 3'd3,
      S_STEP1 = 3'd4,
      S_STEP2 = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam int WORD_W = 3 * SEL_W + 4;

   state_t              r_state;
   state_t              w_next;
   logic [ITER_W-1:0]   r_remaining;
   logic [ITER_W-1:0]   r_iter_cnt;
   logic [SEL_W-1:0]    r_m0, r_m1, r_m2;
   logic                r_lx, r_ls, r_lh, r_h;
   logic                r_busy, r_done;
   logic                w_in_body;
   logic                w_hold;

   // Control word packed as {M0, LX, M1, M2, LS, LH, H}.
   function automatic logic [WORD_W-1:0] f_word(input state_t s);
      case (s)
         S_LOAD:  f_word = {SEL_W'(0), 1'b1, SEL_W'(1), SEL_W'(0), 1'b0, 1'b1, 1'b1};
         S_MUL:   f_word = {SEL_W'(1), 1'b0, SEL_W'(0), SEL_W'(3), 1'b1, 1'b0, 1'b1};
         S_ACC:   f_word = {SEL_W'(2), 1'b0, SEL_W'(0), SEL_W'(0), 1'b0, 1'b1, 1'b1};
         S_STEP1: f_word = {SEL_W'(0), 1'b0, SEL_W'(2), SEL_W'(3), 1'b1, 1'b0, 1'b0};
         S_STEP2: f_word = {SEL_W'(3), 1'b0, SEL_W'(0), SEL_W'(2), 1'b1, 1'b0, 1'b0};
         default: f_word = '0;
      endcase
   endfunction

   assign w_in_body = (r_state == S_MUL) || (r_state == S_ACC) ||
                      (r_state == S_STEP1) || (r_state == S_STEP2);
   assign w_hold    = pause && w_in_body;

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = inicio ? S_LOAD : S_IDLE;
         S_LOAD:  w_next = (r_remaining == '0) ? S_DONE : S_MUL;
         S_MUL:   w_next = pause ? S_MUL   : S_ACC;
         S_ACC:   w_next = pause ? S_ACC   : S_STEP1;
         S_STEP1: w_next = pause ? S_STEP1 : S_STEP2;
         S_STEP2: w_next = pause ? S_STEP2 :
                           ((r_remaining == ITER_W'(1)) ? S_DONE : S_MUL);
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_iter_cnt  <= '0;
         {r_m0, r_lx, r_m1, r_m2, r_ls, r_lh, r_h} <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_next;
         {r_m0, r_lx, r_m1, r_m2, r_ls, r_lh, r_h} <= f_word(w_next);
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (w_next == S_DONE);
         if (r_state == S_IDLE && inicio) begin
            r_remaining <= n_iter;
            r_iter_cnt  <= '0;
         end else if (r_state == S_STEP2 && !pause) begin
            r_remaining <= r_remaining - ITER_W'(1);
            r_iter_cnt  <= r_iter_cnt + ITER_W'(1);
         end
      end
   end

   assign LX       = r_lx & ~w_hold;
   assign LS       = r_ls & ~w_hold;
   assign LH       = r_lh & ~w_hold;
   assign H        = r_h;
   assign M0       = r_m0;
   assign M1       = r_m1;
   assign M2       = r_m2;
   assign busy     = r_busy;
   assign done     = r_done;
   assign iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_bc_seq_ctrl.sv
// Directed bench for bc_seq_ctrl: reset, single/multi/zero runs, pause, ignored start,
// mid-run reset and back-to-back starts, each checked cycle by cycle.
module tb_bc_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset, inicio, pause;
   logic [3:0] n_iter;
   logic       LX, LS, LH, H, busy, done;
   logic [1:0] M0, M1, M2;
   logic [3:0] iter_cnt;
   logic [9:0] w_obs;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [9:0] LOAD_MASK = 10'b11_0_11_11_0_0_1;

   bc_seq_ctrl #(.SEL_W(2), .ITER_W(4)) dut (
      .clk(clk), .reset(reset), .inicio(inicio), .n_iter(n_iter), .pause(pause),
      .LX(LX), .LS(LS), .LH(LH), .H(H), .M0(M0), .M1(M1), .M2(M2),
      .busy(busy), .done(done), .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;

   assign w_obs = {M0, LX, M1, M2, LS, LH, H};

   // State index: 0 IDLE, 1 LOAD, 2 MUL, 3 ACC, 4 STEP1, 5 STEP2, 6 DONE.
   function automatic int exp_state(input int c, input int n);
      if (c == 1)         return 1;
      if (c < 2 + 4 * n)  return 2 + ((c - 2) % 4);
      if (c == 2 + 4 * n) return 6;
      return 0;
   endfunction

   function automatic logic [3:0] exp_iter(input int c, input int n);
      if (c < 2)          return 4'd0;
      if (c >= 2 + 4 * n) return 4'(n);
      return 4'((c - 2) / 4);
   endfunction

   function automatic logic [9:0] exp_word(input int s);
      case (s)
         1:       return {2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 1'b1};
         2:       return {2'd1, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1};
         3:       return {2'd2, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1};
         4:       return {2'd0, 1'b0, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0};
         5:       return {2'd3, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0};
         default: return 10'd0;
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b0; inicio = 1'b0; pause = 1'b0; n_iter = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({w_obs, busy, done, iter_cnt} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_hold: got word=%h busy=%b done=%b iter=%0d, expected all zero",
                  w_obs, busy, done, iter_cnt);
      end
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_tests++;
         if ({w_obs, busy, done, iter_cnt} !== 16'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset c=%0d: got word=%h busy=%b done=%b iter=%0d, expected all zero",
                     c, w_obs, busy, done, iter_cnt);
         end
      end
   endtask

   task automatic test_single();
      int s;
      n_iter = 4'd1; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         s = exp_state(c, 1);
         n_tests++;
         if (w_obs !== exp_word(s) || busy !== (s != 0) || done !== (s == 6) ||
             iter_cnt !== exp_iter(c, 1)) begin
            n_fail++;
            $display("FAIL single c=%0d: got word=%h busy=%b done=%b iter=%0d, expected word=%h busy=%b done=%b iter=%0d",
                     c, w_obs, busy, done, iter_cnt, exp_word(s), s != 0, s == 6, exp_iter(c, 1));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_loop3_and_zero();
      int s;
      n_iter = 4'd3; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         s = exp_state(c, 3);
         n_tests++;
         if (w_obs !== exp_word(s) || busy !== (s != 0) || done !== (s == 6) ||
             iter_cnt !== exp_iter(c, 3)) begin
            n_fail++;
            $display("FAIL loop3 c=%0d: got word=%h busy=%b done=%b iter=%0d, expected word=%h busy=%b done=%b iter=%0d",
                     c, w_obs, busy, done, iter_cnt, exp_word(s), s != 0, s == 6, exp_iter(c, 3));
         end
         @(posedge clk); #1;
      end
      n_iter = 4'd0; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         s = exp_state(c, 0);
         n_tests++;
         if (w_obs !== exp_word(s) || busy !== (s != 0) || done !== (s == 6) ||
             iter_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL zero_iter c=%0d: got word=%h busy=%b done=%b iter=%0d, expected word=%h busy=%b done=%b iter=0",
                     c, w_obs, busy, done, iter_cnt, exp_word(s), s != 0, s == 6);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_pause();
      int s;
      int ec;
      logic [9:0] ew;
      n_iter = 4'd2; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         pause = (c >= 3 && c <= 5);
         #1;
         ec = (c < 3) ? c : ((c <= 5) ? 3 : c - 3);
         s  = exp_state(ec, 2);
         ew = exp_word(s);
         if (pause) ew = ew & LOAD_MASK;
         n_tests++;
         if (w_obs !== ew || busy !== (s != 0) || done !== (s == 6) ||
             iter_cnt !== exp_iter(ec, 2)) begin
            n_fail++;
            $display("FAIL pause c=%0d: got word=%h busy=%b done=%b iter=%0d, expected word=%h busy=%b done=%b iter=%0d",
                     c, w_obs, busy, done, iter_cnt, ew, s != 0, s == 6, exp_iter(ec, 2));
         end
         @(posedge clk); #1;
      end
      pause = 1'b0;
   endtask

   task automatic test_ignore_and_reset();
      int s;
      n_iter = 4'd2; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (c == 4) begin inicio = 1'b1; n_iter = 4'd5; end
         if (c == 5) inicio = 1'b0;
         s = exp_state(c, 2);
         n_tests++;
         if (w_obs !== exp_word(s) || busy !== (s != 0) || done !== (s == 6) ||
             iter_cnt !== exp_iter(c, 2)) begin
            n_fail++;
            $display("FAIL ignore_start c=%0d: got word=%h busy=%b done=%b iter=%0d, expected word=%h busy=%b done=%b iter=%0d",
                     c, w_obs, busy, done, iter_cnt, exp_word(s), s != 0, s == 6, exp_iter(c, 2));
         end
         @(posedge clk); #1;
      end
      n_iter = 4'd3; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         s = exp_state(c, 3);
         n_tests++;
         if (w_obs !== exp_word(s) || busy !== 1'b1 || iter_cnt !== exp_iter(c, 3)) begin
            n_fail++;
            $display("FAIL pre_reset_run c=%0d: got word=%h busy=%b iter=%0d, expected word=%h busy=1 iter=%0d",
                     c, w_obs, busy, iter_cnt, exp_word(s), exp_iter(c, 3));
         end
         if (c == 6) reset = 1'b0;
         @(posedge clk); #1;
      end
      n_tests++;
      if ({w_obs, busy, done, iter_cnt} !== 16'h0) begin
         n_fail++;
         $display("FAIL midrun_reset: got word=%h busy=%b done=%b iter=%0d, expected all zero",
                  w_obs, busy, done, iter_cnt);
      end
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         n_tests++;
         if ({w_obs, busy, done, iter_cnt} !== 16'h0) begin
            n_fail++;
            $display("FAIL after_midrun_reset c=%0d: got word=%h busy=%b done=%b iter=%0d, expected all zero",
                     c, w_obs, busy, done, iter_cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      int s;
      int m;
      int d[$];
      logic [3:0] ei;
      n_iter = 4'd1; inicio = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 21; c++) begin
         m  = c % 7;
         s  = (m == 0) ? 0 : ((m <= 5) ? m : 6);
         ei = (m == 6 || m == 0) ? 4'd1 : 4'd0;
         n_tests++;
         if (w_obs !== exp_word(s) || busy !== (s != 0) || done !== (s == 6) ||
             iter_cnt !== ei) begin
            n_fail++;
            $display("FAIL back_to_back c=%0d: got word=%h busy=%b done=%b iter=%0d, expected word=%h busy=%b done=%b iter=%0d",
                     c, w_obs, busy, done, iter_cnt, exp_word(s), s != 0, s == 6, ei);
         end
         if (done === 1'b1) d.push_back(c);
         if (c == 21) inicio = 1'b0;
         @(posedge clk); #1;
      end
      n_tests++;
      if (d.size() != 3) begin
         n_fail++;
         $display("FAIL done_spacing: got %0d done pulses, expected 3", d.size());
      end else if (d[1] - d[0] != 7 || d[2] - d[1] != 7) begin
         n_fail++;
         $display("FAIL done_spacing: got gaps %0d and %0d, expected 7 and 7",
                  d[1] - d[0], d[2] - d[1]);
      end
      for (int c = 0; c < 3; c++) begin
         n_tests++;
         if (w_obs !== 10'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle c=%0d: got word=%h busy=%b done=%b, expected idle zeros",
                     c, w_obs, busy, done);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_loop3_and_zero();
      test_pause();
      test_ignore_and_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
